detect_ctrl: RTL and testbench

DETECT_CTRL -- requirements
Module: detect_ctrl

---
 rtl/detect_pkg.sv | 19 +
 rtl/detect_ctrl_seq_det.sv | 39 +++
 rtl/detect_ctrl.sv | 110 +++++++++++
 tb/tb_detect_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/detect_pkg.sv
// rtl/detect_pkg.sv - shared state encodings and defaults for the "11" detector block
package detect_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'b00,
    CTRL_SHIFT = 2'b01,
    CTRL_DRAIN = 2'b10,
    CTRL_DONE  = 2'b11
  } ctrl_state_t;

  typedef enum logic [1:0] {
    DET_IDLE = 2'b00,
    DET_S0   = 2'b01,
    DET_S1   = 2'b10
  } det_state_t;

endpackage

// File: rtl/detect_ctrl_seq_det.sv
// rtl/detect_ctrl_seq_det.sv - Moore detector, out high after two consecutive 1 inputs
module seq_det
  import detect_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic in,
  output logic out
);

  det_state_t state;
  det_state_t state_nxt;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DET_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state: a 0 input or a clear returns to IDLE; unused encoding also goes to IDLE
  always_comb begin
    state_nxt = DET_IDLE;
    if (!clr && in) begin
      case (state)
        DET_IDLE: state_nxt = DET_S0;
        DET_S0:   state_nxt = DET_S1;
        DET_S1:   state_nxt = DET_S1;
        default:  state_nxt = DET_IDLE;
      endcase
    end
  end

  assign out = (state == DET_S1);

endmodule

// File: rtl/detect_ctrl.sv
// rtl/detect_ctrl.sv - streams a word MSB first through seq_det and counts "11" adjacencies
module detect_ctrl
  import detect_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       count,
  output logic             hit
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  ctrl_state_t      state;
  ctrl_state_t      state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       count_q;
  logic             det_in;
  logic             det_out;
  logic             det_clr;
  logic             last_bit;

  assign last_bit = (bit_cnt == CW'(WIDTH - 1));

  seq_det u_seq_det (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (det_clr),
    .in    (det_in),
    .out   (det_out)
  );

  // controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CTRL_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and detector drive; DRAIN feeds a 0 so the final pair reaches det_out
  always_comb begin
    state_nxt = state;
    det_in    = 1'b0;
    det_clr   = 1'b0;
    case (state)
      CTRL_IDLE: begin
        if (start) begin
          det_clr   = 1'b1;
          state_nxt = CTRL_SHIFT;
        end
      end
      CTRL_SHIFT: begin
        det_in = shift_reg[WIDTH-1];
        if (last_bit) begin
          state_nxt = CTRL_DRAIN;
        end
      end
      CTRL_DRAIN: state_nxt = CTRL_DONE;
      CTRL_DONE:  state_nxt = CTRL_IDLE;
      default:    state_nxt = CTRL_IDLE;
    endcase
  end

  // shift register, bit counter and adjacency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      count_q   <= '0;
    end else begin
      case (state)
        CTRL_IDLE: begin
          if (start) begin
            shift_reg <= data_in;
            bit_cnt   <= '0;
            count_q   <= '0;
          end
        end
        CTRL_SHIFT: begin
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          bit_cnt   <= bit_cnt + CW'(1);
          if (det_out) begin
            count_q <= count_q + 4'd1;
          end
        end
        CTRL_DRAIN: begin
          if (det_out) begin
            count_q <= count_q + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy  = (state == CTRL_SHIFT) || (state == CTRL_DRAIN);
  assign done  = (state == CTRL_DONE);
  assign count = count_q;
  assign hit   = |count_q;

endmodule

// File: tb/tb_detect_ctrl.sv
// tb/tb_detect_ctrl.sv - scoreboard bench for detect_ctrl with a bit-pair reference model
module tb_detect_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
  logic [3:0] count;
  logic       hit;

  int checks;
  int failures;
  int exp_q[$];
  int last_exp;
  int mon_exp;

  detect_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .hit     (hit)
  );

  // free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference: number of adjacent set-bit pairs in the word
  function automatic int model(input logic [7:0] d);
    int n;
    n = 0;
    for (int i = 1; i < 8; i++) begin
      if (d[i-1] && d[i]) n++;
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // monitor: every done pulse consumes one scoreboard entry
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("count", int'(count), mon_exp);
        chk("hit", int'(hit), int'(mon_exp != 0));
      end
    end
  end

  // one scan; cycle k is the interval after the k-th edge following acceptance
  task automatic run_word(input logic [7:0] d, input bit repulse, input bit preset);
    if (!preset) begin
      @(negedge clk);
      start   = 1'b1;
      data_in = d;
    end
    exp_q.push_back(model(d));
    last_exp = model(d);
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", k), int'(busy), int'(k <= 9));
      chk($sformatf("done_c%0d", k), int'(done), int'(k == 10));
      start   = (repulse && (k == 3 || k == 10)) ? 1'b1 : 1'b0;
      data_in = 8'($urandom);
    end
  endtask

  // idle cycles; confirms nothing restarted and the result is held
  task automatic idle(input int n);
    @(negedge clk);
    start = 1'b0;
    chk("idle_busy", int'(busy), 0);
    repeat (n - 1) @(negedge clk);
    chk("hold_count", int'(count), last_exp);
    chk("hold_hit", int'(hit), int'(last_exp != 0));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    last_exp = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    data_in  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_hit", int'(hit), 0);
    rst_n = 1'b1;

    run_word(8'hFF, 1'b0, 1'b0); idle(3);
    run_word(8'hB6, 1'b0, 1'b0); idle(2);
    run_word(8'hAA, 1'b0, 1'b0); idle(2);
    run_word(8'h00, 1'b0, 1'b0); idle(2);
    run_word(8'h03, 1'b0, 1'b0);
    run_word(8'hC0, 1'b0, 1'b0); idle(2);
    run_word(8'hB6, 1'b1, 1'b0); idle(3);

    // abort an FF scan in cycle 5
    @(negedge clk);
    start   = 1'b1;
    data_in = 8'hFF;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_count", int'(count), 0);
    chk("abort_hit", int'(hit), 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", int'(done), 0);
    start   = 1'b1;
    data_in = 8'h0F;
    @(negedge clk);
    rst_n = 1'b1;
    run_word(8'h0F, 1'b0, 1'b1); idle(2);

    for (int r = 0; r < 20; r++) begin
      int gap;
      run_word(8'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap + 1);
    end
    idle(3);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
